// File: rtl/irq_pkg.sv
// Shared definitions for the machine-level interrupt controller: register
// offsets within the 256-byte window, claim-ID width and service-state encoding.
package irq_pkg;

    localparam logic [7:0] OFF_MSIP    = 8'h00;
    localparam logic [7:0] OFF_ENABLE  = 8'h04;
    localparam logic [7:0] OFF_PENDING = 8'h08;
    localparam logic [7:0] OFF_TRIG    = 8'h0C;
    localparam logic [7:0] OFF_CLAIM   = 8'h10;

    // IDs 1..8 plus "none" (0) fit in four bits.
    localparam int ID_W = 4;

    typedef enum logic {
        IRQ_IDLE       = 1'b0,
        IRQ_IN_SERVICE = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line, followed by a
// rising-edge detector on the synchronised level.
module irq_sync (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic sync_p0, sync_p1, prev_p2;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: timer/software/external interrupt levels to the
// core, with per-line edge/level qualification, fixed priority and claim/complete.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_EXT = 8,
    parameter logic [23:0] BASE    = 24'h2000_01
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               systemTimerIRQ,
    input  logic [NUM_EXT-1:0] extIRQ,
    input  logic [31:0]        A,
    input  logic               WE,
    input  logic               RE,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic               sel,
    output logic               mtip,
    output logic               msip,
    output logic               meip
);

    logic [NUM_EXT-1:0] ext_level, ext_rise;
    logic [NUM_EXT-1:0] enable_q, trig_q, pend_q, pend_d;
    logic [NUM_EXT-1:0] pending, active, best_onehot, clr_mask;
    logic               msip_q;
    irq_state_t         state_q, state_d;
    logic [ID_W-1:0]    claimed_q, claimed_d, best_id;
    logic               meip_d, claim_fire;
    logic [7:0]         offset;
    logic               wr_en, claim_rd, claim_wr;
    logic               unused_wd;

    for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
        irq_sync u_sync (
            .CLK   (CLK),
            .reset (reset),
            .d     (extIRQ[g]),
            .level (ext_level[g]),
            .rise  (ext_rise[g])
        );
    end

    function automatic logic [ID_W-1:0] lowest_id(input logic [NUM_EXT-1:0] v);
        lowest_id = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (v[i]) lowest_id = ID_W'(i + 1);
        end
    endfunction

    assign sel       = (A[31:8] == BASE);
    assign offset    = A[7:0];
    assign wr_en     = sel && WE;
    assign claim_wr  = wr_en && (offset == OFF_CLAIM);
    // A simultaneous write to CLAIM wins over the read side effect.
    assign claim_rd  = sel && RE && !WE && (offset == OFF_CLAIM);
    assign unused_wd = ^WD;

    // Edge lines present their sticky bit, level lines the synchronised input.
    assign pending     = (trig_q & pend_q) | (~trig_q & ext_level);
    assign active      = pending & enable_q;
    assign best_id     = lowest_id(active);
    assign best_onehot = active & (~active + NUM_EXT'(1));

    always_comb begin
        state_d    = state_q;
        claimed_d  = claimed_q;
        meip_d     = 1'b0;
        claim_fire = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (claim_rd && (best_id != '0)) begin
                    claim_fire = 1'b1;
                    claimed_d  = best_id;
                    state_d    = IRQ_IN_SERVICE;
                end else begin
                    meip_d = (best_id != '0);
                end
            end
            IRQ_IN_SERVICE: begin
                if (claim_wr && (WD[ID_W-1:0] == claimed_q)) begin
                    state_d = IRQ_IDLE;
                    meip_d  = (best_id != '0);
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // A fresh edge in the same cycle as a clear leaves the bit set.
    always_comb begin
        clr_mask = '0;
        if (wr_en && (offset == OFF_PENDING)) clr_mask = WD[NUM_EXT-1:0];
        if (claim_fire) clr_mask = clr_mask | best_onehot;
        pend_d = ((pend_q & ~clr_mask) | ext_rise) & trig_q;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            msip_q    <= 1'b0;
            enable_q  <= '0;
            trig_q    <= '0;
            pend_q    <= '0;
            state_q   <= IRQ_IDLE;
            claimed_q <= '0;
            mtip      <= 1'b0;
            meip      <= 1'b0;
        end else begin
            if (wr_en && (offset == OFF_MSIP))   msip_q   <= WD[0];
            if (wr_en && (offset == OFF_ENABLE)) enable_q <= WD[NUM_EXT-1:0];
            if (wr_en && (offset == OFF_TRIG))   trig_q   <= WD[NUM_EXT-1:0];
            pend_q    <= pend_d;
            state_q   <= state_d;
            claimed_q <= claimed_d;
            mtip      <= systemTimerIRQ;
            meip      <= meip_d;
        end
    end

    assign msip = msip_q;

    always_comb begin
        RD = '0;
        if (sel) begin
            case (offset)
                OFF_MSIP:    RD[0]           = msip_q;
                OFF_ENABLE:  RD[NUM_EXT-1:0] = enable_q;
                OFF_PENDING: RD[NUM_EXT-1:0] = pending;
                OFF_TRIG:    RD[NUM_EXT-1:0] = trig_q;
                OFF_CLAIM:   if (state_q == IRQ_IDLE) RD[ID_W-1:0] = best_id;
                default:     RD = '0;
            endcase
        end
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-level interrupt controller sitting directly downstream of the system timer. It takes the timer's level interrupt, a software interrupt bit and up to eight asynchronous external lines, and presents registered `mtip`/`msip`/`meip` levels to the core's CSR/trap logic. External sources are synchronised, edge- or level-qualified, masked, prioritised and serviced through a claim/complete handshake. It is memory-mapped on the same bus as the timer, in the window immediately above it.

## Interface
- `NUM_EXT`, 8: number of external interrupt lines (1..8); IDs are 1..NUM_EXT, and 0 means "none".
- `BASE`, 24'h2000_01: value of A[31:8] that selects this block.

Ports:
- `CLK`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `systemTimerIRQ`  in  1  level interrupt from the system timer
- `extIRQ`  in  NUM_EXT  asynchronous external lines, active-high
- `A`  in  32  bus address
- `WE`  in  1  write strobe
- `RE`  in  1  read strobe (needed for the claim side effect)
- `WD`  in  32  write data
- `RD`  out  32  read data (combinational)
- `sel`  out  1  asserted when A[31:8] == BASE
- `mtip`, `msip`, `meip`  out  1 each  registered interrupt levels to the core

## Operation
Register map (A[7:0]); unmapped reads return 0, unmapped writes are ignored:
- 0x00 MSIP: bit0 is read/write and drives `msip`.
- 0x04 ENABLE[NUM_EXT-1:0]: read/write, per-line enable.
- 0x08 PENDING: reads the pending vector. Writing 1 clears an edge-line bit; level-line bits are not writable.
- 0x0C TRIG[NUM_EXT-1:0]: read/write; 1 = edge-triggered, 0 = level.
- 0x10 CLAIM: a read returns the current best ID and has the claim side effect. A write of an ID is a complete.

Per-line input conditioning:
- Each line passes through a 2-flop synchroniser, then a rising-edge detector.
- Edge line: the pending bit is set on a detected rising edge and held until cleared.
- Level line: the pending bit equals the synchronised input.

Priority and service state:
- `best` = lowest index i with pending[i] & enable[i]; reported ID = i+1, or 0 if there is none.
- FSM states:
  - IDLE: `meip` next = (best != 0).
  - IN_SERVICE: holds the claimed ID; `meip` next = 0 (no nesting).
- Claim (sel & RE & A[7:0]==0x10 while IDLE with best != 0): for an edge line, clear pending[best]; latch the ID; go to IN_SERVICE. A claim read while IDLE with best == 0 returns 0 and causes no transition.
- A claim read while IN_SERVICE returns 0 and has no side effect.
- Complete (write to 0x10 while IN_SERVICE with WD[3:0] == claimed ID): go to IDLE. A mismatched ID is ignored.
- `mtip` = systemTimerIRQ registered by one flop; `msip` = MSIP bit.

## Timing
- On reset, every register, synchroniser flop, the pending vector, `mtip`, `msip` and `meip` is 0; the FSM is in IDLE and the claimed ID is 0. Reset asserted mid-service returns the FSM to IDLE and drops all pending bits.
- External edge to pending bit: 3 rising CLK edges (2 sync + 1 edge detect/pending). `meip` rises 1 cycle after that (4 edges total).
- Timer to `mtip`: 1 cycle. MSIP write to `msip`: visible the cycle after the write edge.
- A new edge on the same line in the same cycle as a claim or W1C clear leaves the pending bit set (set wins).
- While IN_SERVICE, pending bits keep accumulating. After complete, `meip` reasserts 1 cycle later if best != 0.
- RD is combinational from A and current state. Claim and complete take effect at the CLK edge where the strobe is sampled.
- Simultaneous RE and WE to 0x10: the write is processed and the claim is suppressed.

## Structure
- Package `irq_pkg`: register offset constants (OFF_MSIP, OFF_ENABLE, OFF_PENDING, OFF_TRIG, OFF_CLAIM) and the state enum `irq_state_t` {IRQ_IDLE, IRQ_IN_SERVICE}.
- Sub-module `irq_sync`: 2-flop synchroniser plus rising-edge pulse, with asynchronous active-low reset; instantiated NUM_EXT times.
- The top level holds the registers, pending logic, priority encoder, FSM and output flops.

## Test plan
- Reset release with all inputs at 0 → every output and every register reads 0. Set systemTimerIRQ=1 → `mtip`=1 exactly 1 cycle later.
- TRIG=0xFF, ENABLE=0x0C, pulse extIRQ[3] and extIRQ[2] in the same cycle → `meip`=1 after 4 edges. CLAIM read returns 3; `meip`=0 next cycle; PENDING=0x08. Write CLAIM=3 → `meip`=1 next cycle; next claim returns 4.
- Level line 5 enabled, extIRQ[5] held high, claim returns 6, complete with 2 → stays IN_SERVICE and `meip` stays 0. Complete with 6 → `meip` reasserts.
- Edge on line 0 arriving in the same cycle as a W1C of PENDING bit 0 → PENDING bit 0 remains 1.
- Write MSIP=1 → `msip`=1; write MSIP=0 → `msip`=0. Assert reset while IN_SERVICE → FSM IDLE, PENDING=0, all outputs 0.
